// File: rtl/pipelined_addsub_unit.sv
// Pipelined two's-complement add/subtract. CHUNK bits are resolved per stage and the carry is registered between stages.
// Define ADDSUB_OVF_EN to build the signed-overflow output; otherwise ovf is tied low.
module pipelined_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             b_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic [WIDTH-1:0]  x_q   [STAGES];
    logic [WIDTH-1:0]  x_d   [STAGES];
    logic [WIDTH-1:0]  y_q   [STAGES];
    logic [WIDTH-1:0]  y_d   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [CHUNK:0]    sum   [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] mode_q, mode_d;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cin;
    logic              advance;

    assign out_valid = vld_q[LAST];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    // Subtraction becomes X + ~Y + ~b_in, so the borrow is the inverted final carry.
    always_comb begin
        x_d[0]    = X;
        y_d[0]    = Y ^ {WIDTH{mode}};
        res_d[0]  = '0;
        cin[0]    = b_in ^ mode;
        mode_d[0] = mode;
        vld_d[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            x_d[k]    = x_q[k-1];
            y_d[k]    = y_q[k-1];
            res_d[k]  = res_q[k-1];
            cin[k]    = c_q[k-1];
            mode_d[k] = mode_q[k-1];
            vld_d[k]  = vld_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sum[k] = {1'b0, x_d[k][k*CHUNK +: CHUNK]}
                   + {1'b0, y_d[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cin[k]};
            res_d[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
            c_d[k] = sum[k][CHUNK];
        end
    end

    // Stage registers; the last stage doubles as the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            res_q[LAST]  <= '0;
            c_q[LAST]    <= 1'b0;
            mode_q[LAST] <= 1'b0;
        end else if (advance) begin
            vld_q  <= vld_d;
            c_q    <= c_d;
            mode_q <= mode_d;
            for (int k = 0; k < STAGES; k++) begin
                x_q[k]   <= x_d[k];
                y_q[k]   <= y_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign D     = res_q[LAST];
    assign b_out = c_q[LAST] ^ mode_q[LAST];

`ifdef ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // y_d already holds ~Y for subtraction, so one sign rule covers both modes.
    assign ovf_d = (x_d[LAST][WIDTH-1] == y_d[LAST][WIDTH-1])
                && (res_d[LAST][WIDTH-1] != x_d[LAST][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Scoreboard bench for pipelined_addsub_unit: main 32/8 instance plus 16/16 and 64/4 parameter sweeps.
module tb_pipelined_addsub_unit;
    localparam int W  = 32;
    localparam int C  = 8;
    localparam int ST = W / C;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
        int          due;
        bit          lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, mode, b_in, out_valid, out_ready, b_out, ovf;
    logic [W-1:0] X, Y, D;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    bit           rdy_rand = 1'b0;
    exp_t         sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .X(X), .Y(Y), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .b_out(b_out), .ovf(ovf)
    );

    // Reference: plain wide arithmetic; returns {ovf, b_out, D}.
    function automatic logic [65:0] ref_model(int w, bit m, logic [63:0] x, logic [63:0] y, bit bi);
        logic [64:0]        mask, xm, ym, bw, r;
        logic signed [67:0] sx, sy, sb, sr, lim;
        logic               bo, ov;
        mask = (65'd1 << w) - 65'd1;
        xm   = {1'b0, x} & mask;
        ym   = {1'b0, y} & mask;
        bw   = {64'd0, bi};
        if (!m) begin
            r  = xm + ym + bw;
            bo = r[w];
        end else begin
            r  = xm - ym - bw;
            bo = (xm < ym + bw);
        end
        sx = {3'b000, xm};
        if (xm[w-1]) sx = sx - (68'sd1 <<< w);
        sy = {3'b000, ym};
        if (ym[w-1]) sy = sy - (68'sd1 <<< w);
        sb  = {67'd0, bi};
        sr  = m ? (sx - sy - sb) : (sx + sy + sb);
        lim = 68'sd1 <<< (w - 1);
        ov  = (sr >= lim) || (sr < -lim);
`ifndef ADDSUB_OVF_EN
        ov = 1'b0;
`endif
        return {ov, bo, r[63:0] & mask[63:0]};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic send(bit m, logic [W-1:0] x, logic [W-1:0] y, bit bi, bit lat);
        int          n;
        exp_t        e;
        logic [65:0] r;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; mode = m; X = x; Y = y; b_in = bi;
        #2;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout: in_ready stuck at 0 after %0d cycles, expected 1", n);
        end else begin
            r = ref_model(W, m, {32'd0, x}, {32'd0, y}, bi);
            e.d = r[63:0]; e.bo = r[64]; e.ov = r[65]; e.due = cyc + ST; e.lat = lat;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
        end
    endtask

    // Monitor: chooses out_ready, then checks the output against the scoreboard.
    initial begin : monitor
        exp_t        e;
        bit          held;
        logic [W-1:0] hd;
        logic        hbo, hov;
        held = 1'b0; hd = '0; hbo = 1'b0; hov = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (rst) begin
                held = 1'b0;
            end else begin
                check("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
                if (held) begin
                    checks++;
                    if (!out_valid || D !== hd || b_out !== hbo || ovf !== hov) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b D=%h b_out=%b ovf=%b, expected v=1 D=%h b_out=%b ovf=%b",
                                 out_valid, D, b_out, ovf, hd, hbo, hov);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got D=%h with empty scoreboard, expected no beat", D);
                    end else begin
                        e = sbq.pop_front();
                        if (D !== e.d[W-1:0] || b_out !== e.bo || ovf !== e.ov) begin
                            errors++;
                            $display("FAIL result: got D=%h b_out=%b ovf=%b, expected D=%h b_out=%b ovf=%b",
                                     D, b_out, ovf, e.d[W-1:0], e.bo, e.ov);
                        end
                        if (e.lat) check("latency_cycle", 64'(cyc), 64'(e.due));
                    end
                end
                held = out_valid && !out_ready;
                hd = D; hbo = b_out; hov = ovf;
            end
        end
    end

    // Parameter sweep instances, each with its own stream and scoreboard (out_ready held 1).
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int SW  = (g == 0) ? 16 : 64;
        localparam int SC  = (g == 0) ? 16 : 4;
        localparam int SST = SW / SC;
        logic          srst, siv, sir, smode, sbin, sov, sor, sbo, sovf;
        logic [SW-1:0] sx, sy, sd;
        exp_t          q[$];
        bit            done = 1'b0;

        pipelined_addsub_unit #(.WIDTH(SW), .CHUNK(SC)) u_dut (
            .clk(clk), .rst(srst), .in_valid(siv), .in_ready(sir), .mode(smode),
            .X(sx), .Y(sy), .b_in(sbin), .out_valid(sov), .out_ready(sor),
            .D(sd), .b_out(sbo), .ovf(sovf)
        );

        initial begin
            logic [63:0] tx, ty;
            logic [65:0] r;
            exp_t        e;
            int          n;
            srst = 1'b1; siv = 1'b0; sor = 1'b1; smode = 1'b0; sbin = 1'b0; sx = '0; sy = '0;
            repeat (2) @(negedge clk);
            srst = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                tx = {$urandom, $urandom};
                ty = {$urandom, $urandom};
                siv = ($urandom_range(0, 3) != 0); smode = $urandom_range(0, 1) != 0;
                sbin = $urandom_range(0, 1) != 0;
                sx = tx[SW-1:0]; sy = ty[SW-1:0];
                #2;
                if (siv && sir) begin
                    r = ref_model(SW, smode, 64'(sx), 64'(sy), sbin);
                    e.d = r[63:0]; e.bo = r[64]; e.ov = r[65]; e.due = cyc + SST; e.lat = 1'b1;
                    q.push_back(e);
                end
            end
            @(negedge clk);
            siv = 1'b0;
            n = 0;
            while (q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                errors++; checks++;
                $display("FAIL sweep%0d_drain: %0d outstanding, expected 0", g, q.size());
            end
            done = 1'b1;
        end

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                #1;
                if (!srst && sov) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sweep%0d_unexpected: got D=%h, expected no beat", g, sd);
                    end else begin
                        e = q.pop_front();
                        if (sd !== e.d[SW-1:0] || sbo !== e.bo || sovf !== e.ov) begin
                            errors++;
                            $display("FAIL sweep%0d_result: got D=%h b_out=%b ovf=%b, expected D=%h b_out=%b ovf=%b",
                                     g, sd, sbo, sovf, e.d[SW-1:0], e.bo, e.ov);
                        end
                        check("sweep_latency", 64'(cyc), 64'(e.due));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [W-1:0] rx, ry;
        int           n;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; X = '0; Y = '0; b_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_D", 64'(D), 64'd0);
        check("reset_b_out", 64'(b_out), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        send(1'b1, 32'd7, 32'd5, 1'b0, 1'b1);
        send(1'b1, 32'd7, 32'd5, 1'b1, 1'b1);
        send(1'b1, 32'h101, 32'h17, 1'b1, 1'b1);
        send(1'b1, 32'h101, 32'h17, 1'b0, 1'b1);
        send(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
        send(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
        send(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        send(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
        idle();
        drain();

        rdy_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            rx = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            ry = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
            send($urandom_range(0, 1) != 0, rx, ry, $urandom_range(0, 1) != 0, 1'b0);
        end
        idle();
        drain();
        @(negedge clk);
        rdy_rand = 1'b0;

        send(1'b0, 32'd1, 32'd2, 1'b0, 1'b0);
        send(1'b1, 32'd3, 32'd4, 1'b1, 1'b0);
        send(1'b0, 32'd5, 32'd6, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; mode = 1'b0; X = 32'd123; Y = 32'd0; b_in = 1'b0;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("midreset_D", 64'(D), 64'd0);
        check("midreset_b_out", 64'(b_out), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < ST + 2; i++) begin
            check("midreset_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            #1;
        end
        send(1'b1, 32'd9, 32'd4, 1'b0, 1'b1);
        idle();
        drain();

        n = 0;
        while (!(g_sweep[0].done && g_sweep[1].done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(g_sweep[0].done && g_sweep[1].done)) begin
            errors++; checks++;
            $display("FAIL sweep_timeout: sweeps not complete after %0d cycles, expected complete", n);
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
